xbar_router: RTL and testbench
==============================

XBAR_ROUTER -- requirements
Module: xbar_router

Interface
REQ-001 Parameter TIMEOUT, default 1024, cycles a forwarded request may wait for slave handshake plus response before an error response is returned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_valid / a_ready  input / output  1 / 1  master request handshake.
REQ-005 a_opcode  input  3  master request opcode.
REQ-006 a_address  input  64  master request address.
REQ-007 a_data / a_mask  input  64 / 8  master write data and byte mask.
REQ-008 d_valid / d_ready  output / input  1 / 1  master response handshake.
REQ-009 d_data / d_error  output  64 / 1  response data; error flag (unmapped or timeout).
REQ-010 pma_address  output  64  latched request address presented to the address decoder.
REQ-011 pma_chip_sel / pma_chip_addr  input  6 / 64  decoder result (combinational from pma_address).
REQ-012 s_a_valid / s_a_ready  output / input  3 / 3  per-slave request handshake; bit0 ROM, bit1 UART, bit2 RAM.
REQ-013 s_a_opcode, s_a_address, s_a_data, s_a_mask  output  3, 64, 64, 8  shared slave request fields; address is chip-relative.
REQ-014 s_d_valid / s_d_ready  input / output  3 / 3  per-slave response handshake.
REQ-015 s_d_data / s_d_error  input  192 / 3  per-slave response data (slave i at bits 64i+63:64i) and error.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, FWD, WAIT, RSP; exactly one transaction outstanding.
REQ-017 a_ready SHALL be 1 only in IDLE; a_valid&&a_ready latches opcode, address, data, mask; IDLE -> DECODE.
REQ-018 pma_address SHALL drive the latched address at all times (0 after reset).
REQ-019 DECODE (one cycle): latch pma_chip_sel and pma_chip_addr; sel 1/2/3 -> target port 0/1/2, go FWD; any other sel (incl. 0) -> d_data=0, d_error=1, go RSP.
REQ-020 FWD: s_a_valid[target]=1, other bits 0; shared fields hold latched opcode, data, mask and latched chip_addr; on s_a_ready[target] -> WAIT.
REQ-021 Request fields SHALL stay stable while s_a_valid is high.
REQ-022 WAIT: s_d_ready[target]=1; on s_d_valid[target] capture data and error into d_data/d_error, go RSP.
REQ-023 s_d_ready bits of non-target ports SHALL be 1 in every state (stale responses drained and dropped); target port bit is 0 outside WAIT.
REQ-024 RSP: d_valid=1, d_data/d_error stable until d_ready; on d_ready -> IDLE; earliest new accept the next cycle.
REQ-025 Timeout counter SHALL clear on entering FWD, increment each cycle in FWD and WAIT, saturate; at count == TIMEOUT-1 without completing handshake -> d_data=0, d_error=1, drop s_a_valid, go RSP.
REQ-026 Handshake completion and timeout in the same cycle: completion wins.
REQ-027 Minimum latency accept -> d_valid with zero-wait slave: 4 cycles (DECODE, FWD, WAIT, RSP).

Reset
REQ-028 On rst_n low, immediately: state IDLE, a_ready=1, d_valid=0, d_data=0, d_error=0, s_a_valid=0, s_a_* fields 0, pma_address=0, counter 0, s_d_ready=3'b111.
REQ-029 Reset mid-transaction SHALL abandon it with no response; any later slave response is drained per REQ-023.

Verification
REQ-030 Read a_address=0x80000010, decoder sel=3/addr=0x10, RAM ready immediately, returns 0xDEADBEEF -> s_a_valid=3'b100, s_a_address=0x10; d_data=0xDEADBEEF, d_error=0, d_valid 4 cycles after accept.
REQ-031 a_address=0x20 (sel=0) -> no s_a_valid; d_valid with d_error=1, d_data=0, 2 cycles after accept.
REQ-032 UART write address 0x10000004, s_a_ready held low 5 cycles, d_ready held low 3 cycles -> fields stable throughout; one response; a_ready low until d_ready.
REQ-033 TIMEOUT=8, ROM never responds -> d_error=1 after 8 cycles in FWD/WAIT; late ROM s_d_valid consumed (s_d_ready=1), no second master response.
REQ-034 rst_n pulsed low during WAIT -> outputs at reset values same cycle; next request completes normally.

Source files
------------

// File: rtl/xbar_router.sv
// Purpose: single-outstanding router from one master port to ROM/UART/RAM slaves via an external address decoder.
// Latency: accept to d_valid is 4 cycles with a zero-wait slave, 2 for an unmapped address, TIMEOUT+2 on timeout.
// Backpressure: a_ready only in IDLE; the request is held until s_a_ready and the response until d_ready; stale slave responses are drained.
module xbar_router #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [2:0]   a_opcode,
    input  logic [63:0]  a_address,
    input  logic [63:0]  a_data,
    input  logic [7:0]   a_mask,
    output logic         d_valid,
    input  logic         d_ready,
    output logic [63:0]  d_data,
    output logic         d_error,
    output logic [63:0]  pma_address,
    input  logic [5:0]   pma_chip_sel,
    input  logic [63:0]  pma_chip_addr,
    output logic [2:0]   s_a_valid,
    input  logic [2:0]   s_a_ready,
    output logic [2:0]   s_a_opcode,
    output logic [63:0]  s_a_address,
    output logic [63:0]  s_a_data,
    output logic [7:0]   s_a_mask,
    input  logic [2:0]   s_d_valid,
    output logic [2:0]   s_d_ready,
    input  logic [191:0] s_d_data,
    input  logic [2:0]   s_d_error
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, DECODE, FWD, WAIT, RSP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    opcode_q, opcode_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   data_q, data_d;
    logic [7:0]    mask_q, mask_d;
    logic [63:0]   chip_addr_q, chip_addr_d;
    logic [1:0]    tgt_q, tgt_d;
    logic          tgt_vld_q, tgt_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   d_data_q, d_data_d;
    logic          d_error_q, d_error_d;
    logic          a_ready_q, a_ready_d;
    logic          d_valid_q, d_valid_d;
    logic [2:0]    s_a_valid_q, s_a_valid_d;
    logic [2:0]    s_d_ready_q, s_d_ready_d;

    logic [2:0]    tgt_oh, tgt_oh_d;
    logic [63:0]   rsp_data;
    logic          timed_out;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        chip_addr_d = chip_addr_q;
        tgt_d       = tgt_q;
        tgt_vld_d   = tgt_vld_q;
        cnt_d       = cnt_q;
        d_data_d    = d_data_q;
        d_error_d   = d_error_q;

        tgt_oh    = 3'b001 << tgt_q;
        timed_out = (cnt_q >= CNT_LAST);
        case (tgt_q)
            2'd1:    rsp_data = s_d_data[127:64];
            2'd2:    rsp_data = s_d_data[191:128];
            default: rsp_data = s_d_data[63:0];
        endcase

        if ((state_q == FWD || state_q == WAIT) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (a_valid) begin
                    opcode_d = a_opcode;
                    addr_d   = a_address;
                    data_d   = a_data;
                    mask_d   = a_mask;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                chip_addr_d = pma_chip_addr;
                case (pma_chip_sel)
                    6'd1, 6'd2, 6'd3: begin
                        tgt_d     = pma_chip_sel[1:0] - 2'd1;
                        tgt_vld_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = FWD;
                    end
                    default: begin
                        d_data_d  = '0;
                        d_error_d = 1'b1;
                        state_d   = RSP;
                    end
                endcase
            end
            FWD: begin
                // A handshake landing on the last counted cycle still completes.
                if ((s_a_ready & tgt_oh) != 3'b000) begin
                    state_d = WAIT;
                end else if (timed_out) begin
                    d_data_d  = '0;
                    d_error_d = 1'b1;
                    state_d   = RSP;
                end
            end
            WAIT: begin
                if ((s_d_valid & tgt_oh) != 3'b000) begin
                    d_data_d  = rsp_data;
                    d_error_d = (s_d_error & tgt_oh) != 3'b000;
                    state_d   = RSP;
                end else if (timed_out) begin
                    d_data_d  = '0;
                    d_error_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (d_ready) begin
                    tgt_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are derived from the next state so they come straight off flops.
        tgt_oh_d    = 3'b001 << tgt_d;
        a_ready_d   = (state_d == IDLE);
        d_valid_d   = (state_d == RSP);
        s_a_valid_d = (state_d == FWD) ? tgt_oh_d : 3'b000;
        if (state_d == WAIT || !tgt_vld_d) begin
            s_d_ready_d = 3'b111;
        end else begin
            s_d_ready_d = ~tgt_oh_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            chip_addr_q <= '0;
            tgt_q       <= '0;
            tgt_vld_q   <= 1'b0;
            cnt_q       <= '0;
            d_data_q    <= '0;
            d_error_q   <= 1'b0;
            a_ready_q   <= 1'b1;
            d_valid_q   <= 1'b0;
            s_a_valid_q <= 3'b000;
            s_d_ready_q <= 3'b111;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            chip_addr_q <= chip_addr_d;
            tgt_q       <= tgt_d;
            tgt_vld_q   <= tgt_vld_d;
            cnt_q       <= cnt_d;
            d_data_q    <= d_data_d;
            d_error_q   <= d_error_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            s_a_valid_q <= s_a_valid_d;
            s_d_ready_q <= s_d_ready_d;
        end
    end

    assign a_ready     = a_ready_q;
    assign d_valid     = d_valid_q;
    assign d_data      = d_data_q;
    assign d_error     = d_error_q;
    assign pma_address = addr_q;
    assign s_a_valid   = s_a_valid_q;
    assign s_a_opcode  = opcode_q;
    assign s_a_address = chip_addr_q;
    assign s_a_data    = data_q;
    assign s_a_mask    = mask_q;
    assign s_d_ready   = s_d_ready_q;

endmodule

// File: tb/tb_xbar_router.sv
// Randomized scoreboard bench for xbar_router: reference expectations come from the address map,
// the slave delay settings and the timeout budget; a monitor pops and compares each master response.
module tb_xbar_router;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [2:0]   a_opcode = '0;
    logic [63:0]  a_address = '0;
    logic [63:0]  a_data = '0;
    logic [7:0]   a_mask = '0;
    logic         d_valid;
    logic         d_ready = 1'b0;
    logic [63:0]  d_data;
    logic         d_error;
    logic [63:0]  pma_address;
    logic [5:0]   pma_chip_sel;
    logic [63:0]  pma_chip_addr;
    logic [2:0]   s_a_valid;
    logic [2:0]   s_a_ready = '0;
    logic [2:0]   s_a_opcode;
    logic [63:0]  s_a_address;
    logic [63:0]  s_a_data;
    logic [7:0]   s_a_mask;
    logic [2:0]   s_d_valid = '0;
    logic [2:0]   s_d_ready;
    logic [191:0] s_d_data = '0;
    logic [2:0]   s_d_error = '0;

    xbar_router #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_address(a_address),
        .a_data(a_data), .a_mask(a_mask),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_error(d_error),
        .pma_address(pma_address), .pma_chip_sel(pma_chip_sel), .pma_chip_addr(pma_chip_addr),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_data(s_d_data), .s_d_error(s_d_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Address map: ROM 0x1_0000, UART 0x1000_0000, RAM 0x8000_0000, a bogus chip 5 at 0x2000_0000.
    always_comb begin
        pma_chip_sel  = 6'd0;
        pma_chip_addr = 64'd0;
        if (pma_address[63:16] == 48'h1) begin
            pma_chip_sel = 6'd1; pma_chip_addr = pma_address - 64'h1_0000;
        end else if (pma_address[63:12] == 52'h10000) begin
            pma_chip_sel = 6'd2; pma_chip_addr = pma_address - 64'h1000_0000;
        end else if (pma_address[63:16] == 48'h8000) begin
            pma_chip_sel = 6'd3; pma_chip_addr = pma_address - 64'h8000_0000;
        end else if (pma_address[63:16] == 48'h2000) begin
            pma_chip_sel = 6'd5; pma_chip_addr = pma_address - 64'h2000_0000;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave behaviour knobs, set by the stimulus before each request.
    int          req_dly [3];
    int          rsp_dly [3];
    logic [63:0] rsp_dat [3];
    logic        rsp_err [3];
    int          phase   [3];
    int          acnt    [3];
    int          rcnt    [3];
    bit          ahs     [3];
    bit          dhs     [3];
    int          dr_dly = 0;

    // Expected request on the shared slave bus.
    int          exp_tgt = -1;
    logic [2:0]  exp_opcode;
    logic [63:0] exp_caddr, exp_data;
    logic [7:0]  exp_mask;

    typedef struct {
        logic [63:0] dat;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];
    int   n_issued = 0;
    int   rsp_cnt = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_dly[i] = 0; rsp_dly[i] = 0; rsp_dat[i] = '0; rsp_err[i] = 1'b0;
            phase[i] = 0; acnt[i] = 0; rcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                ahs[i] = s_a_valid[i] && s_a_ready[i];
                dhs[i] = s_d_valid[i] && s_d_ready[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (dhs[i]) begin
                    s_d_valid[i] = 1'b0;
                    phase[i] = 0;
                end
                if (ahs[i] || (phase[i] == 1 && rcnt[i] >= rsp_dly[i])) begin
                    if (ahs[i] && rsp_dly[i] != 0) begin
                        phase[i] = 1;
                        rcnt[i] = 1;
                    end else begin
                        s_d_valid[i] = 1'b1;
                        s_d_data[64*i +: 64] = rsp_dat[i];
                        s_d_error[i] = rsp_err[i];
                        phase[i] = 2;
                    end
                end else if (phase[i] == 1) begin
                    rcnt[i]++;
                end
                if (s_a_valid[i]) begin
                    s_a_ready[i] = (acnt[i] >= req_dly[i]);
                    acnt[i]++;
                end else begin
                    s_a_ready[i] = 1'b0;
                    acnt[i] = 0;
                end
            end
        end
    end

    initial begin
        int dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (d_valid) begin
                d_ready = (dcnt >= dr_dly);
                dcnt++;
            end else begin
                d_ready = 1'b0;
                dcnt = 0;
            end
        end
    end

    initial begin
        logic        dv_prev = 1'b0;
        logic [63:0] hold_dat = '0;
        logic        hold_err = 1'b0;
        exp_t        e;
        logic [2:0]  exp_oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (d_valid && !dv_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", {d_data, d_error}, 65'd0);
                        errors += (checks > 0 && d_valid) ? 0 : 0;
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_data", d_data, e.dat);
                        chk("rsp_error", d_error, e.err);
                        chk("rsp_latency", cyc - e.acc, e.lat);
                    end
                    hold_dat = d_data;
                    hold_err = d_error;
                end else if (d_valid) begin
                    chk("rsp_stable", {d_data, d_error}, {hold_dat, hold_err});
                end
                if (d_valid) chk("a_ready_low_in_rsp", a_ready, 1'b0);
                if (d_valid && d_ready) rsp_cnt++;
                if (s_a_valid != 3'b000) begin
                    exp_oh = (exp_tgt >= 0) ? (3'b001 << exp_tgt) : 3'b000;
                    chk("slave_req", {s_a_valid, s_a_opcode, s_a_address, s_a_data, s_a_mask},
                        {exp_oh, exp_opcode, exp_caddr, exp_data, exp_mask});
                end
            end
            dv_prev = d_valid;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_a_ready"}, a_ready, 1'b1);
        chk({tag, "_d_fields"}, {d_valid, d_data, d_error}, 66'd0);
        chk({tag, "_s_a"}, {s_a_valid, s_a_opcode, s_a_address, s_a_data, s_a_mask}, 142'd0);
        chk({tag, "_pma"}, pma_address, 64'd0);
        chk({tag, "_s_d_ready"}, s_d_ready, 3'b111);
    endtask

    // tgt: -1 unmapped, 0 ROM, 1 UART, 2 RAM.
    task automatic issue(input logic [63:0] addr, input int tgt, input logic [63:0] caddr,
                         input int rq, input int rsd, input int drd, input bit push);
        exp_t e;
        bit   acc_ok = 1'b0;
        exp_tgt    = tgt;
        exp_opcode = 3'($urandom_range(0, 7));
        exp_data   = {$urandom(), $urandom()};
        exp_mask   = 8'($urandom_range(0, 255));
        exp_caddr  = caddr;
        dr_dly     = drd;
        if (tgt < 0) begin
            e.dat = '0; e.err = 1'b1; e.lat = 2;
        end else begin
            req_dly[tgt] = rq;
            rsp_dly[tgt] = rsd;
            rsp_dat[tgt] = {$urandom(), $urandom()};
            rsp_err[tgt] = 1'($urandom_range(0, 1));
            if (rq + rsd + 2 <= TO) begin
                e.dat = rsp_dat[tgt]; e.err = rsp_err[tgt]; e.lat = rq + rsd + 4;
            end else begin
                e.dat = '0; e.err = 1'b1; e.lat = TO + 2;
            end
        end
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_address = addr; a_opcode = exp_opcode; a_data = exp_data; a_mask = exp_mask;
        for (int k = 0; k < 50 && !acc_ok; k++) begin
            @(negedge clk);
            acc_ok = a_ready;
        end
        chk("accept", acc_ok, 1'b1);
        e.acc = cyc;
        if (acc_ok && push) begin
            sb.push_back(e);
            n_issued++;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_address = {$urandom(), $urandom()}; a_opcode = 3'($urandom_range(0, 7));
        a_data = {$urandom(), $urandom()}; a_mask = 8'($urandom_range(0, 255));
        if (push) begin
            for (int k = 0; k < 300 && rsp_cnt < n_issued; k++) @(negedge clk);
            chk("rsp_done", rsp_cnt, n_issued);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int          r;
        logic [63:0] off;
        #1 rst_n = 1'b0;
        #1 check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(64'h8000_0010, 2, 64'h10, 0, 0, 0, 1'b1);
        issue(64'h20, -1, 64'h0, 0, 0, 0, 1'b1);
        issue(64'h2000_0100, -1, 64'h0, 0, 0, 1, 1'b1);
        issue(64'h1000_0004, 1, 64'h4, 5, 0, 3, 1'b1);

        issue(64'h1_0008, 0, 64'h8, 0, 12, 0, 1'b1);
        idle(25);
        chk("no_extra_rsp", rsp_cnt, n_issued);
        chk("rom_drained", s_d_valid[0], 1'b0);
        issue(64'h1_0010, 0, 64'h10, 255, 0, 0, 1'b1);
        issue(64'h8000_0040, 2, 64'h40, 0, 6, 0, 1'b1);
        issue(64'h1000_0008, 1, 64'h8, 6, 0, 2, 1'b1);
        issue(64'h8000_0080, 2, 64'h80, 3, 4, 0, 1'b1);
        idle(25);
        chk("ram_drained", s_d_valid[2], 1'b0);

        issue(64'h8000_0100, 2, 64'h100, 0, 6, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("in_wait_s_d_ready", {s_a_valid, s_d_ready}, {3'b000, 3'b111});
        #2 rst_n = 1'b0;
        exp_tgt = -1;
        #1 check_reset("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        chk("ram_drained_after_reset", s_d_valid[2], 1'b0);
        chk("no_rsp_after_reset", rsp_cnt, n_issued);
        issue(64'h8000_0200, 2, 64'h200, 1, 1, 1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 4);
            off = 64'($urandom_range(0, 16'hFFFF));
            case (r)
                0: issue(64'h1_0000 + off, 0, off, $urandom_range(0, 3), $urandom_range(0, 2),
                         $urandom_range(0, 2), 1'b1);
                1: issue(64'h1000_0000 + (off & 64'hFFF), 1, off & 64'hFFF, $urandom_range(0, 3),
                         $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
                2: issue(64'h8000_0000 + off, 2, off, $urandom_range(0, 3), $urandom_range(0, 2),
                         $urandom_range(0, 2), 1'b1);
                3: issue(off, -1, 64'h0, 0, 0, $urandom_range(0, 2), 1'b1);
                default: issue(64'h2000_0000 + off, -1, 64'h0, 0, 0, $urandom_range(0, 2), 1'b1);
            endcase
            idle($urandom_range(0, 2));
        end
        idle(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
